// File: rtl/grn_sched.sv
// grn_sched: batch scheduler that walks consecutive configurations through one grn core
// and streams one result record per configuration. Define GRN_SCHED_TIMEOUT_EN to build in the watchdog.
module grn_sched #(
    parameter int          SIZE           = 69,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            job_start,
    input  logic [SIZE-1:0] job_base,
    input  logic [31:0]     job_count,
    output logic            job_busy,
    output logic            job_done,
    output logic            core_rst,
    output logic            core_start,
    output logic            core_done_ack,
    output logic [SIZE-1:0] core_conf,
    input  logic            core_done,
    input  logic [31:0]     core_transient,
    input  logic [31:0]     core_length,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [SIZE-1:0] res_conf,
    output logic [31:0]     res_transient,
    output logic [31:0]     res_length,
    output logic            res_timeout
);
    localparam logic [2:0] ST_SETTLE = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_ACK    = 3'd4;
    localparam logic [2:0] ST_EMIT   = 3'd5;
    localparam logic [2:0] ST_CRST   = 3'd6;

    localparam logic [SIZE-1:0] CONF_ONE = {{(SIZE-1){1'b0}}, 1'b1};

    logic [2:0]      state_r, state_s;
    logic [SIZE-1:0] cur_conf_r, cur_conf_s;
    logic [31:0]     remaining_r, remaining_s;
    logic [1:0]      settle_cnt_r, settle_cnt_s;
    logic            settle_to_emit_r, settle_to_emit_s;
    logic            job_done_r, job_done_s;
    logic            job_busy_r, core_start_r, core_done_ack_r, res_valid_r;
    logic [SIZE-1:0] res_conf_r, res_conf_s;
    logic [31:0]     res_transient_r, res_transient_s;
    logic [31:0]     res_length_r, res_length_s;
`ifdef GRN_SCHED_TIMEOUT_EN
    localparam logic [31:0] WD_LAST = TIMEOUT_CYCLES - 32'd1;
    logic [31:0]     wd_cnt_r, wd_cnt_s;
    logic            res_timeout_r, res_timeout_s;
`endif

    // Next-state, counter and result-capture decisions of the scheduler FSM
    always_comb begin
        state_s          = state_r;
        cur_conf_s       = cur_conf_r;
        remaining_s      = remaining_r;
        settle_cnt_s     = settle_cnt_r;
        settle_to_emit_s = settle_to_emit_r;
        job_done_s       = 1'b0;
        res_conf_s       = res_conf_r;
        res_transient_s  = res_transient_r;
        res_length_s     = res_length_r;
`ifdef GRN_SCHED_TIMEOUT_EN
        wd_cnt_s         = wd_cnt_r;
        res_timeout_s    = res_timeout_r;
`endif
        case (state_r)
            ST_SETTLE: begin
                if (settle_cnt_r == 2'd1) begin
                    settle_cnt_s     = 2'd0;
                    settle_to_emit_s = 1'b0;
                    state_s          = settle_to_emit_r ? ST_EMIT : ST_IDLE;
                end else begin
                    settle_cnt_s = settle_cnt_r + 2'd1;
                end
            end
            ST_IDLE: begin
                if (job_start) begin
                    cur_conf_s  = job_base;
                    remaining_s = job_count;
                    if (job_count == 32'd0) begin
                        job_done_s = 1'b1;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
`ifdef GRN_SCHED_TIMEOUT_EN
                wd_cnt_s = 32'd0;
`endif
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the same cycle as the watchdog limit takes priority
                if (core_done) begin
                    res_conf_s      = cur_conf_r;
                    res_transient_s = core_transient;
                    res_length_s    = core_length;
`ifdef GRN_SCHED_TIMEOUT_EN
                    res_timeout_s   = 1'b0;
`endif
                    state_s         = ST_ACK;
                end
`ifdef GRN_SCHED_TIMEOUT_EN
                else if (wd_cnt_r == WD_LAST) begin
                    res_conf_s      = cur_conf_r;
                    res_transient_s = 32'hFFFF_FFFF;
                    res_length_s    = 32'hFFFF_FFFF;
                    res_timeout_s   = 1'b1;
                    settle_cnt_s    = 2'd0;
                    state_s         = ST_CRST;
                end else begin
                    wd_cnt_s = (wd_cnt_r == 32'hFFFF_FFFF) ? wd_cnt_r : wd_cnt_r + 32'd1;
                end
`else
                else begin
                    state_s = ST_WAIT;
                end
`endif
            end
            ST_ACK: begin
                state_s = ST_EMIT;
            end
            ST_EMIT: begin
                if (res_ready) begin
                    cur_conf_s  = cur_conf_r + CONF_ONE;
                    remaining_s = remaining_r - 32'd1;
                    if (remaining_r == 32'd1) begin
                        job_done_s = 1'b1;
                        state_s    = ST_IDLE;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_CRST: begin
                if (settle_cnt_r == 2'd1) begin
                    settle_cnt_s     = 2'd0;
                    settle_to_emit_s = 1'b1;
                    state_s          = ST_SETTLE;
                end else begin
                    settle_cnt_s = settle_cnt_r + 2'd1;
                end
            end
            default: begin
                settle_cnt_s     = 2'd0;
                settle_to_emit_s = 1'b0;
                state_s          = ST_SETTLE;
            end
        endcase
    end

    // State, datapath and output registers; control outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= ST_SETTLE;
            cur_conf_r       <= {SIZE{1'b0}};
            remaining_r      <= 32'd0;
            settle_cnt_r     <= 2'd0;
            settle_to_emit_r <= 1'b0;
            job_done_r       <= 1'b0;
            job_busy_r       <= 1'b1;
            core_start_r     <= 1'b0;
            core_done_ack_r  <= 1'b0;
            res_valid_r      <= 1'b0;
            res_conf_r       <= {SIZE{1'b0}};
            res_transient_r  <= 32'd0;
            res_length_r     <= 32'd0;
`ifdef GRN_SCHED_TIMEOUT_EN
            wd_cnt_r         <= 32'd0;
            res_timeout_r    <= 1'b0;
`endif
        end else begin
            state_r          <= state_s;
            cur_conf_r       <= cur_conf_s;
            remaining_r      <= remaining_s;
            settle_cnt_r     <= settle_cnt_s;
            settle_to_emit_r <= settle_to_emit_s;
            job_done_r       <= job_done_s;
            job_busy_r       <= (state_s != ST_IDLE);
            core_start_r     <= (state_s == ST_ISSUE);
            core_done_ack_r  <= (state_s == ST_ACK);
            res_valid_r      <= (state_s == ST_EMIT);
            res_conf_r       <= res_conf_s;
            res_transient_r  <= res_transient_s;
            res_length_r     <= res_length_s;
`ifdef GRN_SCHED_TIMEOUT_EN
            wd_cnt_r         <= wd_cnt_s;
            res_timeout_r    <= res_timeout_s;
`endif
        end
    end

    // The core must be held in reset for as long as the scheduler itself is
    assign core_rst      = ~rst_n | (state_r == ST_CRST);
    assign job_busy      = job_busy_r;
    assign job_done      = job_done_r;
    assign core_start    = core_start_r;
    assign core_done_ack = core_done_ack_r;
    assign core_conf     = cur_conf_r;
    assign res_valid     = res_valid_r;
    assign res_conf      = res_conf_r;
    assign res_transient = res_transient_r;
    assign res_length    = res_length_r;
`ifdef GRN_SCHED_TIMEOUT_EN
    assign res_timeout   = res_timeout_r;
`else
    assign res_timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_grn_sched.sv
// Self-checking bench for grn_sched: a behavioural core stub plus a record scoreboard
// built from the job parameters (base + i, one record per configuration).
module tb_grn_sched;
    localparam int SZ = 69;

    typedef struct packed {
        logic [SZ-1:0] conf;
        logic [31:0]   tr;
        logic [31:0]   len;
        logic          to;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          job_start = 1'b0;
    logic [SZ-1:0] job_base = '0;
    logic [31:0]   job_count = 32'd0;
    logic          job_busy, job_done, core_rst, core_start, core_done_ack;
    logic [SZ-1:0] core_conf;
    logic          core_done = 1'b0;
    logic [31:0]   core_transient = 32'd0;
    logic [31:0]   core_length = 32'd0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [SZ-1:0] res_conf;
    logic [31:0]   res_transient, res_length;
    logic          res_timeout;

    int   n_checks = 0, n_pass = 0;
    int   n_done = 0, exp_done = 0, n_start = 0, n_overlap = 0;
    int   cur_run = 0, last_run = 0, n_runs = 0;
    rec_t exp_q[$];
    rec_t exp_r;
    logic hs_pend = 1'b0, hs_last = 1'b0;
    logic rand_ready = 1'b0;
    logic hang_en = 1'b0;
    logic [SZ-1:0] hang_conf = '0;

    grn_sched #(.SIZE(SZ), .TIMEOUT_CYCLES(32'd16)) dut (
        .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_base(job_base),
        .job_count(job_count), .job_busy(job_busy), .job_done(job_done),
        .core_rst(core_rst), .core_start(core_start), .core_done_ack(core_done_ack),
        .core_conf(core_conf), .core_done(core_done), .core_transient(core_transient),
        .core_length(core_length), .res_valid(res_valid), .res_ready(res_ready),
        .res_conf(res_conf), .res_transient(res_transient), .res_length(res_length),
        .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_tr(input logic [SZ-1:0] c);
        return c[31:0] ^ c[68:37];
    endfunction

    function automatic logic [31:0] ref_len(input logic [SZ-1:0] c);
        return c[40:9] + 32'd1;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Core stub: finishes a few cycles after start unless told to hang on one configuration
    logic          stub_busy = 1'b0, stub_hang = 1'b0;
    logic [3:0]    stub_dly = 4'd0;
    logic [SZ-1:0] stub_conf = '0;
    always @(posedge clk) begin
        if (core_rst) begin
            stub_busy <= 1'b0;
            core_done <= 1'b0;
        end else if (core_done_ack) begin
            core_done <= 1'b0;
        end else if (core_start) begin
            stub_conf <= core_conf;
            stub_busy <= 1'b1;
            stub_dly  <= 4'($urandom_range(1, 6));
            stub_hang <= hang_en && (core_conf == hang_conf);
        end else if (stub_busy && !stub_hang) begin
            if (stub_dly == 4'd0) begin
                stub_busy      <= 1'b0;
                core_done      <= 1'b1;
                core_transient <= ref_tr(stub_conf);
                core_length    <= ref_len(stub_conf);
            end else begin
                stub_dly <= stub_dly - 4'd1;
            end
        end
    end

    // Monitor: scoreboard on handshakes, latency after a handshake, event counters
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_start && core_done_ack) n_overlap++;
            if (core_start) n_start++;
            if (job_done) n_done++;
            if (core_rst) cur_run++;
            else if (cur_run != 0) begin
                last_run = cur_run;
                n_runs++;
                cur_run = 0;
            end
            if (hs_pend) begin
                if (hs_last) check("done_after_last", job_done, 1'b1);
                else check("restart_lat", core_start, 1'b1);
            end
            hs_pend = 1'b0;
            if (res_valid && res_ready) begin
                check("rec_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_r = exp_q.pop_front();
                    check("res_conf", res_conf, exp_r.conf);
                    check("res_transient", res_transient, exp_r.tr);
                    check("res_length", res_length, exp_r.len);
                    check("res_timeout", res_timeout, exp_r.to);
                    hs_pend = 1'b1;
                    hs_last = (exp_q.size() == 0);
                end
            end
        end else begin
            hs_pend = 1'b0;
            cur_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_job(input logic [SZ-1:0] base, input int count);
        logic [SZ-1:0] c;
        for (int i = 0; i < count; i++) begin
            c = base + SZ'(i);
            exp_q.push_back('{conf: c, tr: ref_tr(c), len: ref_len(c), to: 1'b0});
        end
        exp_done++;
    endtask

    task automatic start_job(input logic [SZ-1:0] base, input logic [31:0] count);
        tick();
        job_base  = base;
        job_count = count;
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (rand_ready) res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!job_busy) break;
        end
        check("idle_reached", job_busy, 1'b0);
    endtask

    task automatic release_and_settle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("settle_busy", job_busy, k < 2);
        end
    endtask

    initial begin
        logic [SZ-1:0] base, cap_conf;
        logic [31:0]   cap_tr, cap_len;
        logic          stable;
        int            snap_start, snap_done, cnt;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_busy", job_busy, 1'b1);
        check("rst_outputs", {job_done, core_start, core_done_ack, res_valid, res_timeout}, 5'd0);
        check("rst_res", {res_conf, res_transient, res_length}, '0);
        release_and_settle();

        // Base 0, three configurations
        expect_job('0, 3);
        start_job('0, 32'd3);
        check("start_lat", core_start, 1'b1);
        wait_idle(200);

        // Zero-length job
        snap_start = n_start;
        exp_done++;
        start_job('1, 32'd0);
        check("zero_done", job_done, 1'b1);
        check("zero_start", core_start, 1'b0);
        check("zero_busy", job_busy, 1'b0);
        repeat (5) tick();
        check("zero_no_issue", n_start, snap_start);

        // Wrap from all ones to zero
        expect_job('1, 2);
        start_job('1, 32'd2);
        wait_idle(200);

        // Back-pressure in EMIT
        base = {$urandom, $urandom, $urandom};
        res_ready = 1'b0;
        expect_job(base, 2);
        start_job(base, 32'd2);
        for (int i = 0; i < 100; i++) begin
            if (res_valid) break;
            tick();
            @(negedge clk);
        end
        check("bp_valid", res_valid, 1'b1);
        cap_conf = res_conf;
        cap_tr = res_transient;
        cap_len = res_length;
        snap_start = n_start;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            @(negedge clk);
            stable &= res_valid && (res_conf == cap_conf) && (res_transient == cap_tr) &&
                      (res_length == cap_len) && !core_start;
        end
        check("bp_stable", stable, 1'b1);
        tick();
        check("bp_no_issue", n_start, snap_start);
        res_ready = 1'b1;
        wait_idle(200);

        // Randomised jobs under random back-pressure
        rand_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            base = {$urandom, $urandom, $urandom};
            cnt = $urandom_range(1, 5);
            expect_job(base, cnt);
            start_job(base, 32'(cnt));
            wait_idle(400);
        end
        rand_ready = 1'b0;
        res_ready = 1'b1;

`ifdef GRN_SCHED_TIMEOUT_EN
        // Watchdog: first configuration hangs, second completes normally
        base = {$urandom, $urandom, $urandom};
        hang_en = 1'b1;
        hang_conf = base;
        exp_q.push_back('{conf: base, tr: 32'hFFFF_FFFF, len: 32'hFFFF_FFFF, to: 1'b1});
        exp_q.push_back('{conf: base + SZ'(1), tr: ref_tr(base + SZ'(1)),
                          len: ref_len(base + SZ'(1)), to: 1'b0});
        exp_done++;
        n_runs = 0;
        start_job(base, 32'd2);
        wait_idle(400);
        check("crst_runs", n_runs, 1);
        check("crst_len", last_run, 2);
        hang_en = 1'b0;
`endif

        // Reset mid-WAIT with an ignored job_start while busy
        base = {$urandom, $urandom, $urandom};
        hang_en = 1'b1;
        hang_conf = base;
        start_job(base, 32'd4);
        repeat (5) tick();
        job_base = ~base;
        job_count = 32'd1;
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        tick();
        rst_n = 1'b0;
        snap_done = n_done;
        tick();
        exp_q.delete();
        hang_en = 1'b0;
        release_and_settle();
        tick();
        snap_start = n_start;
        repeat (10) tick();
        @(negedge clk);
        check("rst_mid_busy", job_busy, 1'b0);
        check("rst_mid_valid", res_valid, 1'b0);
        tick();
        check("rst_mid_no_issue", n_start, snap_start);
        check("rst_mid_no_done", n_done, snap_done);

        // Clean job after the interrupted one
        expect_job(base, 2);
        start_job(base, 32'd2);
        check("post_rst_start", core_start, 1'b1);
        wait_idle(200);

        tick();
        check("queue_drained", exp_q.size(), 0);
        check("done_count", n_done, exp_done);
        check("no_overlap", n_overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
